// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit hex seven-segment scanner, common-anode display.
// Words are captured on load and shown one whole frame at a time.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK       = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    input  logic        freeze,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [31:0]   r_pending;
    logic [31:0]   r_shadow;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_wrap;
    logic          w_frame;
    logic          w_blank;
    logic          w_supp;
    logic          w_en;
    logic [3:0]    w_nib;
    logic [31:0]   w_upper;
    logic [6:0]    w_seg;

    assign w_wrap  = (r_cnt == LAST);
    assign w_frame = w_wrap && (r_idx == 3'd7);

    generate
        if (BLANK == 0) begin : g_noblank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_cnt < CW'(BLANK));
        end
    endgenerate

    // Digit i is a leading zero when nibbles i..7 are all zero.
    assign w_nib   = r_shadow[{r_idx, 2'b00} +: 4];
    assign w_upper = r_shadow >> {r_idx, 2'b00};
    assign w_supp  = blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);
    assign w_en    = !w_blank && !w_supp;

    always_comb begin
        w_seg = 7'h7F;
        unique case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 32'd0;
            r_shadow  <= 32'd0;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_an      <= 8'hFF;
            r_seg     <= 7'h7F;
            r_dp      <= 1'b1;
        end else begin
            if (load && !freeze) begin
                r_pending <= value;
            end
            // Old pending wins on a load that collides with the boundary.
            if (w_frame) begin
                r_shadow <= r_pending;
            end
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_idx <= r_idx + 3'd1;
            end
            r_an  <= w_en ? ~(8'h01 << r_idx) : 8'hFF;
            r_seg <= w_seg;
            r_dp  <= w_en ? ~dp_mask[r_idx] : 1'b1;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
